// File: rtl/demux4_tdm.sv
// Registered 1-to-4 demultiplexer / TDM deframer: routes each accepted sample to one
// of four held channels, chosen by {sel1,sel2} (mode 0) or a sync-aligned slot counter (mode 1).
module demux4_tdm #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             in_valid,
    input  logic             mode,
    input  logic             sel1,
    input  logic             sel2,
    input  logic             sync,
    output logic [WIDTH-1:0] t1,
    output logic [WIDTH-1:0] t2,
    output logic [WIDTH-1:0] t3,
    output logic [WIDTH-1:0] t4,
    output logic             v1,
    output logic             v2,
    output logic             v3,
    output logic             v4,
    output logic [1:0]       slot,
    output logic             frame_done
);

    logic [1:0] ch;
    logic [1:0] slot_d, slot_q;
    logic       frame_done_d, frame_done_q;

    // A sync accompanying a sample forces it into slot 0, so the frame restarts on it.
    always_comb begin
        ch           = mode ? (sync ? 2'd0 : slot_q) : {sel1, sel2};
        slot_d       = slot_q;
        frame_done_d = 1'b0;
        if (!mode) begin
            slot_d = 2'd0;
        end else if (in_valid) begin
            slot_d       = ch + 2'd1;
            frame_done_d = (ch == 2'd3);
        end else if (sync) begin
            slot_d = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q       <= 2'd0;
            frame_done_q <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            frame_done_q <= frame_done_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ch
            logic [WIDTH-1:0] t_d, t_q;
            logic             v_d, v_q;

            always_comb begin
                t_d = t_q;
                v_d = 1'b0;
                if (in_valid && (ch == 2'(gi))) begin
                    t_d = din;
                    v_d = 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    t_q <= '0;
                    v_q <= 1'b0;
                end else begin
                    t_q <= t_d;
                    v_q <= v_d;
                end
            end
        end
    endgenerate

    assign t1         = g_ch[0].t_q;
    assign t2         = g_ch[1].t_q;
    assign t3         = g_ch[2].t_q;
    assign t4         = g_ch[3].t_q;
    assign v1         = g_ch[0].v_q;
    assign v2         = g_ch[1].v_q;
    assign v3         = g_ch[2].v_q;
    assign v4         = g_ch[3].v_q;
    assign slot       = slot_q;
    assign frame_done = frame_done_q;

endmodule
